// File: rtl/led_blink_bank.sv
// led_blink_bank: multi-channel LED activity / heartbeat generator.
// Each channel runs independently in OFF, ON, BLINK or PULSE mode with its own
// half-period. All channels count a shared prescaler tick. Outputs are registered.
module led_blink_bank #(
    parameter int         N_CH     = 8,
    parameter int         CNT_W    = 26,
    parameter int         PRESC    = 1,
    parameter logic [1:0] RST_MODE = 2'd2,
    parameter int         RST_HALF = 50000000,
    localparam int        CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [1:0]       i_cfg_mode,
    input  logic [CNT_W-1:0] i_cfg_half,
    input  logic [N_CH-1:0]  i_trig,
    input  logic             i_sync_all,
    output logic [N_CH-1:0]  o_led,
    output logic [N_CH-1:0]  o_busy
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    localparam int               PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST   = CNT_W'(RST_HALF);

    logic [PW-1:0]    r_presc;
    logic             w_tick;

    mode_e            r_mode [N_CH];
    logic [CNT_W-1:0] r_half [N_CH];
    logic [CNT_W-1:0] r_cnt  [N_CH];
    logic [N_CH-1:0]  r_led;
    logic [N_CH-1:0]  r_busy;

    logic [CNT_W-1:0] w_last [N_CH];
    logic [N_CH-1:0]  w_hit;

    // Tick qualifier: every cycle when PRESC is 1, else on the last prescaler count.
    always_comb begin
        w_tick = 1'b0;
        if (PRESC <= 1) begin
            w_tick = 1'b1;
        end else if (r_presc == PRESC_LAST) begin
            w_tick = 1'b1;
        end else begin
            w_tick = 1'b0;
        end
    end

    // Shared prescaler; sync_all restarts it so every BLINK channel realigns.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_presc <= {PW{1'b0}};
        end else if (i_sync_all) begin
            r_presc <= {PW{1'b0}};
        end else if (w_tick) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Per-channel config address decode and terminal count (half=0 acts as 1).
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_hit[c]  = 1'b0;
            w_last[c] = CNT_ZERO;
            if (i_cfg_we && (32'(i_cfg_ch) == 32'(c))) begin
                w_hit[c] = 1'b1;
            end else begin
                w_hit[c] = 1'b0;
            end
            if (r_half[c] == CNT_ZERO) begin
                w_last[c] = CNT_ZERO;
            end else begin
                w_last[c] = r_half[c] - CNT_ONE;
            end
        end
    end

    // Channel state: a config write to the channel beats everything else; sync_all
    // only restarts BLINK channels, PULSE/ON/OFF channels carry on as if it were absent.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_mode[c] <= mode_e'(RST_MODE);
                r_half[c] <= HALF_RST;
                r_cnt[c]  <= CNT_ZERO;
            end
            r_led  <= {N_CH{1'b0}};
            r_busy <= {N_CH{1'b0}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_hit[c]) begin
                    r_mode[c] <= mode_e'(i_cfg_mode);
                    r_half[c] <= i_cfg_half;
                    r_cnt[c]  <= CNT_ZERO;
                    r_led[c]  <= (i_cfg_mode == 2'd1);
                    r_busy[c] <= 1'b0;
                end else begin
                    case (r_mode[c])
                        MODE_OFF: begin
                            r_led[c]  <= 1'b0;
                            r_busy[c] <= 1'b0;
                            r_cnt[c]  <= CNT_ZERO;
                        end
                        MODE_ON: begin
                            r_led[c]  <= 1'b1;
                            r_busy[c] <= 1'b0;
                            r_cnt[c]  <= CNT_ZERO;
                        end
                        MODE_BLINK: begin
                            r_busy[c] <= 1'b0;
                            if (i_sync_all) begin
                                r_cnt[c] <= CNT_ZERO;
                                r_led[c] <= 1'b0;
                            end else if (w_tick) begin
                                if (r_cnt[c] >= w_last[c]) begin
                                    r_cnt[c] <= CNT_ZERO;
                                    r_led[c] <= ~r_led[c];
                                end else begin
                                    r_cnt[c] <= r_cnt[c] + CNT_ONE;
                                end
                            end else begin
                                r_cnt[c] <= r_cnt[c];
                            end
                        end
                        MODE_PULSE: begin
                            if (r_busy[c]) begin
                                if (w_tick) begin
                                    if (r_cnt[c] >= w_last[c]) begin
                                        r_cnt[c]  <= CNT_ZERO;
                                        r_led[c]  <= 1'b0;
                                        r_busy[c] <= 1'b0;
                                    end else begin
                                        r_cnt[c] <= r_cnt[c] + CNT_ONE;
                                    end
                                end else begin
                                    r_cnt[c] <= r_cnt[c];
                                end
                            end else if (i_trig[c]) begin
                                r_cnt[c]  <= CNT_ZERO;
                                r_led[c]  <= 1'b1;
                                r_busy[c] <= 1'b1;
                            end else begin
                                r_cnt[c]  <= CNT_ZERO;
                                r_led[c]  <= 1'b0;
                                r_busy[c] <= 1'b0;
                            end
                        end
                        default: begin
                            r_led[c]  <= 1'b0;
                            r_busy[c] <= 1'b0;
                            r_cnt[c]  <= CNT_ZERO;
                        end
                    endcase
                end
            end
        end
    end

    assign o_led  = r_led;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank: directed vectors, a cycle-level behavioural model
// compared every cycle, and hand-computed literal checks on key edges.
module tb_led_blink_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_half;
    logic [3:0] trig;
    logic       sync_all;
    logic [3:0] led;
    logic [3:0] busy;
    logic [1:0] led_b;
    logic [1:0] busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_blink_bank #(.N_CH(4), .CNT_W(8), .PRESC(1), .RST_MODE(2'd2), .RST_HALF(4)) u_dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
        .i_cfg_mode(cfg_mode), .i_cfg_half(cfg_half), .i_trig(trig),
        .i_sync_all(sync_all), .o_led(led), .o_busy(busy)
    );

    led_blink_bank #(.N_CH(2), .CNT_W(8), .PRESC(3), .RST_MODE(2'd2), .RST_HALF(2)) u_dut_b (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_cfg_we(1'b0), .i_cfg_ch(1'b0),
        .i_cfg_mode(2'd0), .i_cfg_half(8'd0), .i_trig(2'b00),
        .i_sync_all(1'b0), .o_led(led_b), .o_busy(busy_b)
    );

    // Behavioural model (PRESC=1): a BLINK led is the parity of elapsed-ticks / Heff
    // since its phase start; a pulse stays high while fewer than Heff ticks elapsed.
    int         m_mode [4];
    int         m_heff [4];
    int         m_t    [4];
    logic [3:0] m_led;
    logic [3:0] m_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_mode[c] <= 2;
                m_heff[c] <= 4;
                m_t[c]    <= 0;
            end
            m_led  <= 4'b0000;
            m_busy <= 4'b0000;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    m_mode[c] <= int'(cfg_mode);
                    m_heff[c] <= (cfg_half == 8'd0) ? 1 : int'(cfg_half);
                    m_t[c]    <= 0;
                    m_led[c]  <= (cfg_mode == 2'd1);
                    m_busy[c] <= 1'b0;
                end else if (m_mode[c] == 0) begin
                    m_led[c] <= 1'b0;
                end else if (m_mode[c] == 1) begin
                    m_led[c] <= 1'b1;
                end else if (m_mode[c] == 2) begin
                    if (sync_all) begin
                        m_t[c]   <= 0;
                        m_led[c] <= 1'b0;
                    end else begin
                        m_t[c]   <= m_t[c] + 1;
                        m_led[c] <= (((m_t[c] + 1) / m_heff[c]) % 2) == 1;
                    end
                end else begin
                    if (m_busy[c]) begin
                        m_t[c] <= m_t[c] + 1;
                        if (m_t[c] + 1 >= m_heff[c]) begin
                            m_busy[c] <= 1'b0;
                            m_led[c]  <= 1'b0;
                        end
                    end else if (trig[c]) begin
                        m_busy[c] <= 1'b1;
                        m_led[c]  <= 1'b1;
                        m_t[c]    <= 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        n_chk = n_chk + 1;
        if ((led !== m_led) || (busy !== m_busy)) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp at %0t: led=%b busy=%b, expected led=%b busy=%b",
                     $time, led, busy, m_led, m_busy);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_half = half;
    endtask

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_mode = 2'd0;
        cfg_half = 8'd0;
        trig     = 4'b0000;
        sync_all = 1'b0;

        // 1: reset state, then all channels blink in phase with half=4
        cyc(3);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cyc(3);
        chk("blink_e3", 32'(led), 32'h0);
        cyc(1);
        chk("blink_e4", 32'(led), 32'hF);
        cyc(4);
        chk("blink_e8", 32'(led), 32'h0);

        // 2: ch2 BLINK half=3
        wr(2'd2, 2'd2, 8'd3);
        cyc(1);
        cfg_we = 1'b0;
        chk("ch2_e0", 32'(led[2]), 32'h0);
        cyc(2);
        chk("ch2_e2", 32'(led[2]), 32'h0);
        cyc(1);
        chk("ch2_e3", 32'(led[2]), 32'h1);
        chk("ch0_undisturbed_a", 32'(led[0]), 32'h1);
        cyc(2);
        chk("ch2_e5", 32'(led[2]), 32'h1);
        cyc(1);
        chk("ch2_e6", 32'(led[2]), 32'h0);
        cyc(3);
        chk("ch2_e9", 32'(led[2]), 32'h1);
        chk("ch0_undisturbed_b", 32'(led[0]), 32'h0);

        // 3: ch1 PULSE half=5, retrigger while busy ignored
        wr(2'd1, 2'd3, 8'd5);
        cyc(1);
        cfg_we  = 1'b0;
        trig[1] = 1'b1;
        cyc(1);
        trig[1] = 1'b0;
        chk("pulse_start_busy", 32'(busy[1]), 32'h1);
        chk("pulse_start_led", 32'(led[1]), 32'h1);
        cyc(2);
        trig[1] = 1'b1;
        cyc(1);
        trig[1] = 1'b0;
        cyc(1);
        chk("pulse_f4_busy", 32'(busy[1]), 32'h1);
        cyc(1);
        chk("pulse_f5_busy", 32'(busy[1]), 32'h0);
        chk("pulse_f5_led", 32'(led[1]), 32'h0);
        cyc(3);

        // 4: ch3 half=0 toggles every cycle, then ON
        wr(2'd3, 2'd2, 8'd0);
        cyc(1);
        cfg_we = 1'b0;
        chk("h0_e0", 32'(led[3]), 32'h0);
        cyc(1);
        chk("h0_e1", 32'(led[3]), 32'h1);
        cyc(1);
        chk("h0_e2", 32'(led[3]), 32'h0);
        wr(2'd3, 2'd1, 8'd0);
        cyc(1);
        cfg_we = 1'b0;
        chk("on_e0", 32'(led[3]), 32'h1);
        cyc(3);
        chk("on_e3", 32'(led[3]), 32'h1);

        // 5: two blink channels written apart, then sync_all (with a config write to ch2)
        wr(2'd0, 2'd2, 8'd4);
        cyc(1);
        cfg_we = 1'b0;
        cyc(1);
        wr(2'd1, 2'd2, 8'd4);
        cyc(1);
        cfg_we = 1'b0;
        cyc(1);
        sync_all = 1'b1;
        wr(2'd2, 2'd1, 8'd7);
        cyc(1);
        sync_all = 1'b0;
        cfg_we   = 1'b0;
        chk("sync_s0", 32'(led[1:0]), 32'h0);
        chk("sync_cfg_ch2_on", 32'(led[2]), 32'h1);
        cyc(3);
        chk("sync_s3", 32'(led[1:0]), 32'h0);
        cyc(1);
        chk("sync_s4", 32'(led[1:0]), 32'h3);

        // config and trig on the same PULSE channel: config wins
        wr(2'd1, 2'd3, 8'd6);
        trig[1] = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
        chk("cfg_beats_trig", 32'(busy[1]), 32'h0);
        cyc(1);
        trig[1] = 1'b0;
        chk("trig_held_fires", 32'(busy[1]), 32'h1);
        cyc(1);

        // 6: async reset between edges clears outputs at once
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        cyc(2);
        rst = 1'b0;

        // PRESC=3, half=2: toggles every 6 cycles, period 12
        cyc(5);
        chk("presc3_e5", 32'(led_b), 32'h0);
        cyc(1);
        chk("presc3_e6", 32'(led_b), 32'h3);
        cyc(5);
        chk("presc3_e11", 32'(led_b), 32'h3);
        cyc(1);
        chk("presc3_e12", 32'(led_b), 32'h0);
        chk("presc3_busy", 32'(busy_b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
